// File: rtl/slope_moving_average_pkg.sv
// Shared DSP definitions for the slope/integration stages: default widths,
// the running-sum width rule and a width-agnostic sign-extend helper.
package heracles_dsp_pkg;

    localparam int unsigned DEFAULT_W     = 64;
    localparam int unsigned DEFAULT_LOG2N = 3;

    // Widest value the sign-extend helper can produce.
    localparam int unsigned SEXT_MAX = 128;

    // A sum of 2^log2n samples of width w needs log2n extra bits.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned log2n);
        return w + log2n;
    endfunction

    // Sign-extend the low w bits of x to SEXT_MAX bits; callers size-cast
    // the operand in and the result back out.
    function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] x, input int unsigned w);
        logic [SEXT_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SEXT_MAX; i++) begin
            r[i] = (i < w) ? x[i] : x[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/slope_moving_average_if.sv
// Sample/average bus between a slope source and the moving-average stage.
interface slope_moving_average_if
    import heracles_dsp_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned LOG2N = DEFAULT_LOG2N
) ();

    logic [W-1:0]   sample_in;
    logic           sample_valid;
    logic           clear;
    logic [W-1:0]   avg_out;
    logic           avg_valid;
    logic           primed;
    logic [LOG2N:0] fill_count;

    modport master (
        output sample_in, sample_valid, clear,
        input  avg_out, avg_valid, primed, fill_count
    );

    modport slave (
        input  sample_in, sample_valid, clear,
        output avg_out, avg_valid, primed, fill_count
    );

endinterface

// File: rtl/slope_sample_ring.sv
// N x W circular sample buffer: the oldest entry is presented combinationally
// at the write pointer and overwritten on the same edge a new sample is written.
module slope_sample_ring
    import heracles_dsp_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned LOG2N = DEFAULT_LOG2N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         flush,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] oldest
);

    localparam int unsigned N = 1 << LOG2N;

    logic [W-1:0]       mem [N];
    logic [LOG2N-1:0]   wr_ptr;

    assign oldest = mem[wr_ptr];

    // Zero all entries on reset/flush so warm-up subtracts zeros; otherwise write-and-advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[LOG2N'(i)] <= '0;
            end
            wr_ptr <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[LOG2N'(i)] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + LOG2N'(1);
        end
    end

endmodule

// File: rtl/slope_moving_average.sv
// Boxcar moving average over the last 2^LOG2N slope samples. Holds the running
// sum and fill/primed status; the average is registered one cycle after accept
// and only flagged valid once the window is full.
module slope_moving_average
    import heracles_dsp_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned LOG2N = DEFAULT_LOG2N
) (
    input logic                  clk,
    input logic                  rst,
    slope_moving_average_if.slave bus
);

    localparam int unsigned    N      = 1 << LOG2N;
    localparam int unsigned    SUM_W  = sum_width(W, LOG2N);
    localparam logic [LOG2N:0] N_FILL = (LOG2N + 1)'(N);

    logic                    accept;
    logic [W-1:0]            oldest;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sample_ext;
    logic signed [SUM_W-1:0] oldest_ext;
    logic [LOG2N:0]          fill;
    logic [LOG2N:0]          fill_inc;
    logic                    primed;
    logic                    pending;
    logic [W-1:0]            avg;
    logic                    avg_valid;

    // clear takes priority: a sample presented alongside it is dropped.
    assign accept     = bus.sample_valid & ~bus.clear;
    assign sample_ext = SUM_W'(sext(SEXT_MAX'(bus.sample_in), W));
    assign oldest_ext = SUM_W'(sext(SEXT_MAX'(oldest), W));
    assign fill_inc   = fill + (LOG2N + 1)'(1);

    slope_sample_ring #(
        .W     (W),
        .LOG2N (LOG2N)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .flush   (bus.clear),
        .wr_data (bus.sample_in),
        .oldest  (oldest)
    );

    // Running sum, fill level and primed status; pending marks an accept whose result is due next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            fill    <= '0;
            primed  <= 1'b0;
            pending <= 1'b0;
        end else if (bus.clear) begin
            sum     <= '0;
            fill    <= '0;
            primed  <= 1'b0;
            pending <= 1'b0;
        end else if (accept) begin
            sum     <= sum + sample_ext - oldest_ext;
            fill    <= (fill == N_FILL) ? N_FILL : fill_inc;
            primed  <= fill_inc >= N_FILL;
            pending <= fill_inc >= N_FILL;
        end else begin
            pending <= 1'b0;
        end
    end

    // Output register: clear on this edge also squashes a result still pending from the previous accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (bus.clear) begin
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (pending) begin
            avg       <= W'(sum >>> LOG2N);
            avg_valid <= 1'b1;
        end else begin
            avg_valid <= 1'b0;
        end
    end

    assign bus.avg_out    = avg;
    assign bus.avg_valid  = avg_valid;
    assign bus.primed     = primed;
    assign bus.fill_count = fill;

endmodule
